// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with single-cycle arithmetic/logic/shift ops and optional iterative MUL/DIV.
// Define ALU_MULDIV_EN to build the iterative multiply/divide datapath and its RUN state.
module alu_iter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flag_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBC = 4'h3;
    localparam logic [3:0] OP_SHL = 4'h4, OP_SHR = 4'h5, OP_ASR = 4'h6;
    localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_NOT = 4'hB;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             accept, iter;
    logic [WIDTH:0]   sum, dif, shl_w, shr_w, asr_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_o, cin;

    assign accept    = start && !busy;
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

    // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
    always_comb begin
        cin    = flags_q[2];
        sum    = {1'b0, src1} + {1'b0, src2} + (WIDTH+1)'(cin && opcode == OP_ADC);
        dif    = {1'b0, src1} - {1'b0, src2} - (WIDTH+1)'(cin && opcode == OP_SBC);
        shl_w  = {1'b0, src1} << src2[SHW-1:0];
        shr_w  = {src1, 1'b0} >> src2[SHW-1:0];
        asr_w  = $signed({src1, 1'b0}) >>> src2[SHW-1:0];
        sc_res = '0;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_o   = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                sc_res = dif[WIDTH-1:0];
                sc_c   = dif[WIDTH];
                sc_o   = (src1[WIDTH-1] != src2[WIDTH-1]) && (dif[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SHL: begin
                sc_res = shl_w[WIDTH-1:0];
                sc_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_res = shr_w[WIDTH:1];
                sc_c   = shr_w[0];
            end
            OP_ASR: begin
                sc_res = asr_w[WIDTH:1];
                sc_c   = asr_w[0];
            end
            OP_AND:  sc_res = src1 & src2;
            OP_OR:   sc_res = src1 | src2;
            OP_XOR:  sc_res = src1 ^ src2;
            OP_NOT:  sc_res = ~src2;
            default: sc_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [3:0]   OP_MUL   = 4'h7, OP_DIV = 4'hC;
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
    logic             div_q, div_d, fen_q, fen_d;
    logic [WIDTH:0]   mul_s, div_t, div_r;
    logic             div_ge;
    logic [WIDTH-1:0] it_acc, it_lo;

    assign iter = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign busy = (state_q == RUN);

    // acc holds the product high half / partial remainder; lo holds the multiplier / quotient.
    always_comb begin
        mul_s  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_t  = {acc_q, lo_q[WIDTH-1]};
        div_ge = div_t >= {1'b0, opb_q};
        div_r  = div_t - {1'b0, opb_q};
        it_acc = div_q ? (div_ge ? div_r[WIDTH-1:0] : div_t[WIDTH-1:0]) : mul_s[WIDTH:1];
        it_lo  = div_q ? {lo_q[WIDTH-2:0], div_ge} : {mul_s[0], lo_q[WIDTH-1:1]};
    end
`else
    assign iter = 1'b0;
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d     = (state_q == DONE) ? IDLE : state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        if (accept) begin
            state_d = iter ? RUN : DONE;
            if (!iter) begin
                result_d    = sc_res;
                result_hi_d = '0;
                if (flag_en) flags_d = {sc_o, sc_c, sc_res[WIDTH-1], ~|sc_res};
            end
        end
`ifdef ALU_MULDIV_EN
        cnt_d = cnt_q;
        acc_d = acc_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        div_d = div_q;
        fen_d = fen_q;
        if (accept && iter) begin
            cnt_d = CNT_INIT;
            acc_d = '0;
            lo_d  = src1;
            opb_d = src2;
            div_d = (opcode == OP_DIV);
            fen_d = flag_en;
        end
        if (state_q == RUN) begin
            cnt_d = cnt_q - 1'b1;
            acc_d = it_acc;
            lo_d  = it_lo;
            if (cnt_q == 1) begin
                state_d     = DONE;
                result_d    = it_lo;
                result_hi_d = it_acc;
                if (fen_q) flags_d = {div_q ? ~|opb_q : |it_acc, !div_q && |it_acc, it_lo[WIDTH-1], ~|it_lo};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
            fen_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
            div_q <= div_d;
            fen_q <= fen_d;
        end
    end
`endif
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed and randomized checks of alu_iter (WIDTH=16) against an arithmetic reference model.
module tb_alu_iter;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opcode = '0;
    logic [15:0] src1 = '0, src2 = '0;
    logic        flag_en = 1'b0;
    logic        busy, done;
    logic [15:0] result, result_hi;
    logic [3:0]  flags;
    logic [3:0]  mf = '0;
    int          checks = 0, errors = 0;

    alu_iter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .src1(src1), .src2(src2),
        .flag_en(flag_en), .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op_in, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, output logic [15:0] r, output logic [15:0] hi,
                                  output logic o, output logic c);
        int          sa, sb, t, ci;
        int unsigned ua, ub, sh, s;
        longint unsigned p;
        logic [3:0]  op;
        op = ((op_in == 4'd7 || op_in == 4'd12) && !MULDIV) ? 4'hF : op_in;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = b[3:0];
        ci = (op == 4'd2 || op == 4'd3) ? int'(cin) : 0;
        r = '0; hi = '0; o = 1'b0; c = 1'b0;
        case (op)
            4'd0, 4'd2: begin
                t = sa + sb + ci; s = ua + ub + ci;
                r = 16'(s); c = s > 65535; o = (t > 32767) || (t < -32768);
            end
            4'd1, 4'd3: begin
                t = sa - sb - ci;
                r = 16'(t); c = ua < ub + ci; o = (t > 32767) || (t < -32768);
            end
            4'd4: begin r = 16'(ua << sh); c = ((ua << sh) & 32'h10000) != 0; end
            4'd5: begin r = 16'(ua >> sh); c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            4'd6: begin r = 16'(sa >>> sh); c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0); end
            4'd7: begin
                p = longint'(ua) * longint'(ub);
                r = 16'(p); hi = 16'(p >> 16); o = hi != 0; c = hi != 0;
            end
            4'd12: begin
                if (ub == 0) begin r = 16'hFFFF; hi = a; o = 1'b1; end
                else begin r = 16'(ua / ub); hi = 16'(ua % ub); end
            end
            4'd8:  r = a & b;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~b;
            default: r = '0;
        endcase
    endfunction

    // Called on a falling edge; returns on the falling edge of the done cycle.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic fen);
        logic [15:0] er, eh;
        logic        eo, ec;
        int          n;
        model(op, a, b, mf[2], er, eh, eo, ec);
        start = 1'b1; opcode = op; src1 = a; src2 = b; flag_en = fen;
        @(negedge clk);
        start = 1'b0;
        if (MULDIV && (op == 4'd7 || op == 4'd12)) begin
            chk("busy_after_accept", 32'(busy), 32'd1);
            chk("done_low_while_busy", 32'(done), 32'd0);
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                if (n == 3) begin
                    start = 1'b1; opcode = 4'd0; src1 = 16'h1234; src2 = 16'h1111; flag_en = 1'b1;
                end else start = 1'b0;
                @(negedge clk);
            end
            start = 1'b0;
            chk("busy_cycles", 32'(n), 32'd16);
        end
        if (fen) mf = {eo, ec, er[15], er == 16'h0};
        chk("done", 32'(done), 32'd1);
        chk("result", 32'(result), 32'(er));
        chk("result_hi", 32'(result_hi), 32'(eh));
        chk("flags", 32'(flags), 32'(mf));
    endtask

    initial begin
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        logic        saw;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_hi", 32'(result_hi), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd0, 16'h7FFF, 16'h0001, 1'b1);
        do_op(4'd1, 16'h0000, 16'h0001, 1'b1);
        do_op(4'd3, 16'h0005, 16'h0002, 1'b1);
        do_op(4'd2, 16'hFFFF, 16'h0000, 1'b1);
        do_op(4'd4, 16'h8001, 16'h0001, 1'b1);
        do_op(4'd6, 16'h8000, 16'h000F, 1'b1);
        do_op(4'd5, 16'h8001, 16'h0000, 1'b1);
        do_op(4'd8, 16'hF0F0, 16'h0FF0, 1'b0);
        do_op(4'd11, 16'h0000, 16'hFFFF, 1'b1);
        do_op(4'd13, 16'h1234, 16'h5678, 1'b1);
        do_op(4'd7, 16'hFFFF, 16'h0002, 1'b1);
        do_op(4'd12, 16'd100, 16'd7, 1'b1);
        do_op(4'd12, 16'd5, 16'd0, 1'b1);
        do_op(4'd9, 16'h00F0, 16'h0F00, 1'b1);
        @(negedge clk);
        chk("done_falls_when_idle", 32'(done), 32'd0);

        // Abort a MUL partway through with a reset.
        start = 1'b1; opcode = 4'd7; src1 = 16'hFFFF; src2 = 16'h0003; flag_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mf = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_result_hi", 32'(result_hi), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        chk("abort_no_done", 32'(saw), 32'd0);
        do_op(4'd0, 16'd1, 16'd1, 1'b1);

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            do_op(rop, ra, rb, 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                chk("gap_done_low", 32'(done), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
